riscv_trace_buffer: RTL and testbench
=====================================

# riscv_trace_buffer

Parametrised execution-trace capture unit attached beside the rv32i core top. Each cycle it samples the core's debug outputs (register writeback and data-memory access), packs any activity into one timestamped record, and buffers records in a FIFO drained over a valid/ready port. It adds what the raw debug pins lack: buffering, back-pressure, an optional core-stall request, loss accounting and a cycle timestamp.

## Interface
Parameters:
- DATA_W, 32, data width of writeback and memory data
- ADDR_W, 9, data-memory address width
- TS_W, 16, timestamp counter width
- DEPTH, 16, FIFO entries; power of two, at least 2
- STALL_ON_FULL, 0, 1 = assert stall_req instead of dropping records

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- trace_en  in  1  capture enable
- reg_write_sig  in  1  writeback valid this cycle
- reg_num  in  5  writeback destination register
- reg_data  in  DATA_W  writeback value
- wr  in  1  data-memory write this cycle
- rd  in  1  data-memory read this cycle
- addr  in  ADDR_W  data-memory address
- wr_data  in  DATA_W  store data
- rd_data  in  DATA_W  load data
- t_valid  out  1  record available
- t_ready  in  1  consumer accepts record
- t_data  out  REC_W  record, REC_W = 2*DATA_W + ADDR_W + TS_W + 9 (98 at defaults)
- stall_req  out  1  core hold request (STALL_ON_FULL=1 only, else 0)
- overflow  out  1  sticky: at least one record dropped
- drop_count  out  16  records dropped, saturates at 16'hFFFF
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Event in a cycle: trace_en & ((reg_write_sig & reg_num != 0) | wr | rd).
- Record, MSB to LSB: lost, ts[TS_W-1:0], wb_v, reg_num[4:0], wb_data, mem_wr, mem_rd, addr, mem_data.
- wb_v = reg_write_sig & reg_num != 0; when wb_v = 0, reg_num and wb_data fields are zero.
- mem_data = wr_data if wr, rd_data if rd only, zero if neither; wr & rd both high recorded as-is (mem_wr = mem_rd = 1, store data).
- ts: free-running counter, increments every cycle regardless of trace_en, wraps modulo 2^TS_W; record carries value of the event cycle.
- lost = 1 on the first record accepted after one or more drops; then cleared.
- Push when event and (not full, or pop in same cycle). Full with no pop: STALL_ON_FULL=0 drops the record, sets overflow, increments drop_count, arms lost; STALL_ON_FULL=1 also drops but that cannot happen if the core honours stall_req.
- stall_req = STALL_ON_FULL & (level >= DEPTH-1), giving one entry of slack for the event already in flight.
- Pop when t_valid & t_ready; t_data holds stable while t_valid & !t_ready.
- Simultaneous push and pop: both take effect, level unchanged; valid at any occupancy including full and empty-plus-push (no bypass: an empty FIFO pushing and popping in the same cycle is impossible since t_valid = 0).
- Pointers are log2(DEPTH) bits, wrap naturally; full/empty from level.
- overflow and drop_count clear only on reset.

## Timing
- Reset (reset = 0, asynchronous): pointers, level, ts, lost, overflow, drop_count = 0; t_valid = 0, stall_req = 0, t_data = 0.
- Capture latency 1: event in cycle N, record visible on t_data with t_valid = 1 in cycle N+1 if FIFO was empty.
- t_data driven from registered head entry; no combinational path from event inputs to t_valid or t_data.
- stall_req and level registered, updated the edge after the push/pop.
- Reset asserted mid-transfer: contents discarded, t_valid falls immediately (asynchronously).

## Structure
- Package riscv_trace_pkg: record field offset/width constants derived from DATA_W, ADDR_W, TS_W; REC_W function; DROP_W = 16.
- Sub-module trace_fifo (generic synchronous FIFO, WIDTH/DEPTH parameters, push/pop/level/full/empty); top handles event detection, packing, timestamp, loss and stall logic.

## Test plan
- Single writeback: reg_write_sig=1, reg_num=5, reg_data=32'hDEADBEEF at ts=3 -> next cycle t_valid=1, wb_v=1, reg_num=5, wb_data=DEADBEEF, ts=3, mem fields 0.
- x0 filter: reg_write_sig=1, reg_num=0, no memory op -> no record, level stays 0.
- Combined store+writeback: wr=1, addr=9'h1F0, wr_data=32'h12, writeback reg 7 = 32'h34 -> one record with both wb_v=1 and mem_wr=1.
- Overflow, STALL_ON_FULL=0, DEPTH=4, t_ready=0: 6 events -> level=4, overflow=1, drop_count=2; release t_ready -> 4 records in order, then next event's record has lost=1.
- Stall mode, DEPTH=4, t_ready=0: level reaches 3 -> stall_req=1 next cycle; one pop -> stall_req falls after level drops to 2.
- Full with simultaneous push/pop and mid-stream async reset: level stays 4 with no drop; reset low -> t_valid=0, level=0, drop_count=0 immediately; ts wraps 16'hFFFF -> 0.

Source files
------------

// File: rtl/riscv_trace_buffer_pkg.sv
// -----------------------------------------------------------------------------
// riscv_trace_pkg
// Shared definitions for the execution-trace capture unit:
//   - DROP_W     : width of the saturating drop counter
//   - mem_op_e   : decoded data-memory operation of a cycle ({wr, rd})
//   - rec_w()    : total record width for a given DATA_W / ADDR_W / TS_W
//   - off_*()    : LSB offset of each record field (record is packed MSB->LSB as
//                  lost, ts, wb_v, reg_num, wb_data, mem_wr, mem_rd, addr, mem_data)
// -----------------------------------------------------------------------------
package riscv_trace_pkg;

    localparam int DROP_W   = 16;
    localparam int REG_NUM_W = 5;

    // Encoding matches the concatenation {wr, rd} so a plain cast decodes it.
    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_RD   = 2'b01,
        MEM_WR   = 2'b10,
        MEM_RW   = 2'b11
    } mem_op_e;

    function automatic int rec_w(input int data_w, input int addr_w, input int ts_w);
        return 2 * data_w + addr_w + ts_w + 9;
    endfunction

    // mem_data always sits at bit 0.
    function automatic int off_addr(input int data_w);
        return data_w;
    endfunction

    function automatic int off_mem_rd(input int data_w, input int addr_w);
        return data_w + addr_w;
    endfunction

    function automatic int off_mem_wr(input int data_w, input int addr_w);
        return data_w + addr_w + 1;
    endfunction

    function automatic int off_wb_data(input int data_w, input int addr_w);
        return data_w + addr_w + 2;
    endfunction

    function automatic int off_reg_num(input int data_w, input int addr_w);
        return 2 * data_w + addr_w + 2;
    endfunction

    function automatic int off_wb_v(input int data_w, input int addr_w);
        return 2 * data_w + addr_w + 7;
    endfunction

    function automatic int off_ts(input int data_w, input int addr_w);
        return 2 * data_w + addr_w + 8;
    endfunction

    function automatic int off_lost(input int data_w, input int addr_w, input int ts_w);
        return 2 * data_w + addr_w + 8 + ts_w;
    endfunction

endpackage

// File: rtl/riscv_trace_buffer_if.sv
// -----------------------------------------------------------------------------
// riscv_trace_buffer_if
// Valid/ready record stream leaving the trace buffer.
//   t_valid : record available (producer -> consumer)
//   t_ready : consumer accepts record (consumer -> producer)
//   t_data  : record payload, W bits (producer -> consumer)
// master = trace buffer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface riscv_trace_buffer_if #(
    parameter int W = 98
) ();
    logic         t_valid;
    logic         t_ready;
    logic [W-1:0] t_data;

    modport master (
        output t_valid,
        output t_data,
        input  t_ready
    );

    modport slave (
        input  t_valid,
        input  t_data,
        output t_ready
    );
endinterface

// File: rtl/riscv_trace_buffer_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Generic synchronous FIFO built from flops with asynchronous active-low reset.
// The head entry is read straight out of the storage registers, so pop_data is
// valid the cycle after a push into an empty FIFO and never depends
// combinationally on push_data.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   push, push_data    : write request and data (ignored when full unless a
//                        pop happens in the same cycle)
//   pop                : read request (ignored when empty)
//   pop_data           : current head entry
//   level, level_nxt   : occupancy now / after the coming edge
//   full, empty        : derived from level
// -----------------------------------------------------------------------------
module trace_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [LVL_W-1:0] level,
    output logic [LVL_W-1:0] level_nxt,
    output logic             full,
    output logic             empty
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] entry_we;
    logic             do_push;
    logic             do_pop;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign entry_we[gi] = do_push && (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (entry_we[i]) begin
                mem_d[i] = push_data;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign pop_data  = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign level_nxt = level_d;

endmodule

// File: rtl/riscv_trace_buffer.sv
// -----------------------------------------------------------------------------
// riscv_trace_buffer
// Samples the rv32i core's debug outputs every cycle, packs any activity into a
// timestamped record and queues it in a FIFO drained over a valid/ready stream.
// Adds loss accounting (sticky overflow, saturating drop counter, lost flag on
// the first record after a gap) and an optional core stall request.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   trace_en            : capture enable
//   reg_write_sig/num/data : register writeback of this cycle
//   wr, rd, addr, wr_data, rd_data : data-memory access of this cycle
//   trace (master)      : t_valid / t_ready / t_data record stream
//   stall_req           : hold request to the core (STALL_ON_FULL=1 only)
//   overflow            : sticky, at least one record dropped
//   drop_count          : dropped records, saturating
//   level               : FIFO occupancy
// -----------------------------------------------------------------------------
module riscv_trace_buffer
    import riscv_trace_pkg::*;
#(
    parameter  int DATA_W        = 32,
    parameter  int ADDR_W        = 9,
    parameter  int TS_W          = 16,
    parameter  int DEPTH         = 16,
    parameter  bit STALL_ON_FULL = 1'b0,
    localparam int REC_W         = rec_w(DATA_W, ADDR_W, TS_W),
    localparam int LVL_W         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trace_en,
    input  logic                  reg_write_sig,
    input  logic [REG_NUM_W-1:0]  reg_num,
    input  logic [DATA_W-1:0]     reg_data,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W-1:0]     rd_data,
    riscv_trace_buffer_if.master  trace,
    output logic                  stall_req,
    output logic                  overflow,
    output logic [DROP_W-1:0]     drop_count,
    output logic [LVL_W-1:0]      level
);

    localparam int O_ADDR    = off_addr(DATA_W);
    localparam int O_MEM_RD  = off_mem_rd(DATA_W, ADDR_W);
    localparam int O_MEM_WR  = off_mem_wr(DATA_W, ADDR_W);
    localparam int O_WB_DATA = off_wb_data(DATA_W, ADDR_W);
    localparam int O_REG_NUM = off_reg_num(DATA_W, ADDR_W);
    localparam int O_WB_V    = off_wb_v(DATA_W, ADDR_W);
    localparam int O_TS      = off_ts(DATA_W, ADDR_W);
    localparam int O_LOST    = off_lost(DATA_W, ADDR_W, TS_W);

    logic              wb_v;
    logic              evt;
    mem_op_e           mem_op;
    logic [DATA_W-1:0] mem_data;
    logic [REC_W-1:0]  rec;
    logic [REC_W-1:0]  head;
    logic              push;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic [LVL_W-1:0]  fifo_level_nxt;

    logic [TS_W-1:0]   ts_q, ts_d;
    logic              lost_q, lost_d;
    logic              overflow_q, overflow_d;
    logic              stall_q, stall_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    // ---------------------------------------------------------------- capture
    always_comb begin
        // Writes to x0 are architecturally discarded, so they are not activity.
        wb_v   = reg_write_sig & (reg_num != '0);
        evt    = trace_en & (wb_v | wr | rd);
        mem_op = mem_op_e'({wr, rd});

        // A cycle with both strobes is recorded as-is, carrying the store data.
        case (mem_op)
            MEM_WR, MEM_RW: mem_data = wr_data;
            MEM_RD:         mem_data = rd_data;
            default:        mem_data = '0;
        endcase

        rec                     = '0;
        rec[O_LOST]             = lost_q;
        rec[O_TS +: TS_W]       = ts_q;
        rec[O_WB_V]             = wb_v;
        if (wb_v) begin
            rec[O_REG_NUM +: REG_NUM_W] = reg_num;
            rec[O_WB_DATA +: DATA_W]    = reg_data;
        end
        rec[O_MEM_WR]           = wr;
        rec[O_MEM_RD]           = rd;
        rec[O_ADDR +: ADDR_W]   = addr;
        rec[0 +: DATA_W]        = mem_data;
    end

    // ---------------------------------------------------------------- queueing
    assign trace.t_valid = ~fifo_empty;
    assign pop           = ~fifo_empty & trace.t_ready;
    assign push          = evt & (~fifo_full | pop);
    assign drop          = evt & fifo_full & ~pop;

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data (rec),
        .pop       (pop),
        .pop_data  (head),
        .level     (fifo_level),
        .level_nxt (fifo_level_nxt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ------------------------------------------------------ timestamp / loss
    always_comb begin
        ts_d       = ts_q + 1'b1;
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
        // Armed by any drop, consumed by the next record that makes it in.
        lost_d = lost_q;
        if (drop) begin
            lost_d = 1'b1;
        end else if (push) begin
            lost_d = 1'b0;
        end
        // Looking at the next level keeps stall_req in step with level; the
        // one spare entry absorbs the event the core already has in flight.
        stall_d = STALL_ON_FULL && (fifo_level_nxt >= LVL_W'(DEPTH - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q       <= '0;
            lost_q     <= 1'b0;
            overflow_q <= 1'b0;
            stall_q    <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_q       <= ts_d;
            lost_q     <= lost_d;
            overflow_q <= overflow_d;
            stall_q    <= stall_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign trace.t_data = head;
    assign stall_req    = stall_q;
    assign overflow     = overflow_q;
    assign drop_count   = drop_cnt_q;
    assign level        = fifo_level;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_riscv_trace_buffer
// Two DEPTH=4 instances share the core-side inputs but have separate capture
// enables: dut_a drops on full (STALL_ON_FULL=0) and is scoreboarded, dut_b
// runs in stall mode and is checked on level / stall_req.
// -----------------------------------------------------------------------------
module tb_riscv_trace_buffer;
    import riscv_trace_pkg::*;

    localparam int REC_W = rec_w(32, 9, 16);
    localparam int LVL_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             trace_en_a = 1'b0;
    logic             trace_en_b = 1'b0;
    logic             reg_write_sig = 1'b0;
    logic [4:0]       reg_num = '0;
    logic [31:0]      reg_data = '0;
    logic             wr = 1'b0;
    logic             rd = 1'b0;
    logic [8:0]       addr = '0;
    logic [31:0]      wr_data = '0;
    logic [31:0]      rd_data = '0;

    logic             stall_a, ovf_a, stall_b, ovf_b;
    logic [15:0]      drop_a, drop_b;
    logic [LVL_W-1:0] lvl_a, lvl_b;

    riscv_trace_buffer_if #(.W(REC_W)) if_a ();
    riscv_trace_buffer_if #(.W(REC_W)) if_b ();

    riscv_trace_buffer #(.DEPTH(4), .STALL_ON_FULL(1'b0)) dut_a (
        .clk(clk), .reset(reset), .trace_en(trace_en_a),
        .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
        .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .trace(if_a.master), .stall_req(stall_a), .overflow(ovf_a),
        .drop_count(drop_a), .level(lvl_a)
    );

    riscv_trace_buffer #(.DEPTH(4), .STALL_ON_FULL(1'b1)) dut_b (
        .clk(clk), .reset(reset), .trace_en(trace_en_b),
        .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
        .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .trace(if_b.master), .stall_req(stall_b), .overflow(ovf_b),
        .drop_count(drop_b), .level(lvl_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [REC_W-1:0] exp_q[$];
    logic [REC_W-1:0] rec_b0;
    logic [15:0]      ts_model;

    // Reference timestamp: free-running count of edges since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) ts_model <= '0;
        else        ts_model <= ts_model + 16'd1;
    end

    function automatic logic [REC_W-1:0] pack(input bit lost, input logic [15:0] ts,
            input bit wbv, input logic [4:0] rn, input logic [31:0] wbd,
            input bit mw, input bit mr, input logic [8:0] a, input logic [31:0] md);
        return {lost, ts, wbv, rn, wbd, mw, mr, a, md};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        trace_en_a = 0; trace_en_b = 0; reg_write_sig = 0; reg_num = 0; reg_data = 0;
        wr = 0; rd = 0; addr = 0; wr_data = 0; rd_data = 0;
    endtask

    // Drives one cycle of core activity; when dut_a should accept it, the
    // record the bench expects is queued for the monitor.
    task automatic drive(input bit tgt, input bit we, input logic [4:0] rn,
            input logic [31:0] rdat, input bit w, input bit r, input logic [8:0] a,
            input logic [31:0] wd, input logic [31:0] rdd, input bit acc, input bit lost);
        bit wbv;
        logic [31:0] md;
        logic [REC_W-1:0] e;
        trace_en_a = !tgt; trace_en_b = tgt;
        reg_write_sig = we; reg_num = rn; reg_data = rdat;
        wr = w; rd = r; addr = a; wr_data = wd; rd_data = rdd;
        wbv = we && (rn != 5'd0);
        md  = w ? wd : (r ? rdd : 32'd0);
        e   = pack(lost, ts_model, wbv, wbv ? rn : 5'd0, wbv ? rdat : 32'd0, w, r, a, md);
        $display("drive dut_%s ts=%0d wb=%0d r%0d=%h wr=%0d rd=%0d addr=%h accept=%0d",
                 tgt ? "b" : "a", ts_model, we, rn, rdat, w, r, a, acc);
        if (!tgt && acc) exp_q.push_back(e);
        if (tgt) rec_b0 = e;
    endtask

    // Scoreboard: every handshake on dut_a must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && if_a.t_valid && if_a.t_ready) begin
            logic [REC_W-1:0] e;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected observed=%h expected=none", if_a.t_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                $display("pop  dut_a t_data=%h expected=%h", if_a.t_data, e);
                assert (if_a.t_data === e) else begin
                    failures++;
                    $error("FAIL sb_record observed=%h expected=%h", if_a.t_data, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        if_a.t_ready = 1'b0;
        if_b.t_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", if_a.t_valid, 1'b0);
        chk("rst_level", lvl_a, 3'd0);
        chk("rst_data", if_a.t_data, '0);
        chk("rst_drop", drop_a, 16'd0);
        chk("rst_ovf", ovf_a, 1'b0);
        chk("rst_stall", stall_b, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        tick();

        // Single writeback at ts=3, one-cycle capture latency.
        if_a.t_ready = 1'b1;
        n = 0;
        while (ts_model != 16'd3 && n < 100) begin tick(); n++; end
        drive(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 9'h0, 0, 0, 1, 0);
        tick(); idle();
        chk("wb_valid", if_a.t_valid, 1'b1);
        chk("wb_level", lvl_a, 3'd1);
        tick();
        chk("wb_drained", lvl_a, 3'd0);

        // x0 writes and disabled capture produce nothing.
        drive(0, 1, 5'd0, 32'h1111, 0, 0, 9'h0, 0, 0, 0, 0);
        tick();
        trace_en_a = 0; reg_num = 5'd9;
        tick(); idle();
        chk("x0_valid", if_a.t_valid, 1'b0);
        chk("x0_level", lvl_a, 3'd0);

        // Store+writeback, load, store+load back to back (push/pop at level 1).
        drive(0, 1, 5'd7, 32'h34, 1, 0, 9'h1F0, 32'h12, 32'hFFFF, 1, 0);
        tick();
        chk("combo_level", lvl_a, 3'd1);
        drive(0, 0, 5'd3, 32'h99, 0, 1, 9'h055, 32'h77, 32'hCAFE, 1, 0);
        tick();
        chk("pushpop_level", lvl_a, 3'd1);
        drive(0, 0, 5'd0, 0, 1, 1, 9'h0AA, 32'h5555, 32'h6666, 1, 0);
        tick(); idle();
        tick();
        chk("mix_drained", lvl_a, 3'd0);

        // Overflow: 6 events into 4 entries with the consumer stalled.
        if_a.t_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 5'(i + 1), 32'h100 + i, 0, 0, 9'h0, 0, 0, i < 4, 0);
            tick();
        end
        idle();
        chk("ovf_level", lvl_a, 3'd4);
        chk("ovf_flag", ovf_a, 1'b1);
        chk("ovf_drop", drop_a, 16'd2);
        chk("ovf_nostall", stall_a, 1'b0);
        if_a.t_ready = 1'b1;
        n = 0;
        while (lvl_a != 3'd0 && n < 20) begin tick(); n++; end
        chk("ovf_drain_level", lvl_a, 3'd0);
        drive(0, 0, 5'd0, 0, 0, 1, 9'h123, 0, 32'hABCD, 1, 1);
        tick(); idle(); tick();
        drive(0, 1, 5'd31, 32'hF00D, 0, 0, 9'h0, 0, 0, 1, 0);
        tick(); idle(); tick();
        chk("ovf_sticky", ovf_a, 1'b1);

        // Full FIFO with simultaneous push/pop, then asynchronous reset.
        if_a.t_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 5'd10, 32'h200 + i, 0, 0, 9'h0, 0, 0, 1, 0);
            tick();
        end
        chk("full_level", lvl_a, 3'd4);
        drive(0, 1, 5'd11, 32'h2FF, 0, 0, 9'h0, 0, 0, 1, 0);
        if_a.t_ready = 1'b1;
        tick();
        if_a.t_ready = 1'b0;
        idle();
        chk("full_pp_level", lvl_a, 3'd4);
        chk("full_pp_drop", drop_a, 16'd2);
        #2 reset = 1'b0;
        #1;
        exp_q.delete();
        $display("async reset asserted mid-stream");
        chk("arst_valid", if_a.t_valid, 1'b0);
        chk("arst_level", lvl_a, 3'd0);
        chk("arst_drop", drop_a, 16'd0);
        chk("arst_ovf", ovf_a, 1'b0);
        @(negedge clk) reset = 1'b1;
        tick();

        // Stall mode on dut_b.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 5'd0, 0, 1, 0, 9'(i), 32'h300 + i, 0, 1, 0);
            if (i == 0) begin
                tick();
                chk("stall_head", if_b.t_data, rec_b0);
            end else begin
                tick();
            end
            chk($sformatf("stall_level%0d", i + 1), lvl_b, 3'(i + 1));
            chk($sformatf("stall_req%0d", i + 1), stall_b, i == 2);
        end
        idle();
        if_b.t_ready = 1'b1;
        tick();
        if_b.t_ready = 1'b0;
        chk("stall_pop_level", lvl_b, 3'd2);
        chk("stall_release", stall_b, 1'b0);
        chk("stall_noovf", ovf_b, 1'b0);

        // Timestamp wrap: records at ts=FFFF and ts=0.
        if_a.t_ready = 1'b1;
        n = 0;
        while (ts_model != 16'hFFFF && n < 70000) begin tick(); n++; end
        drive(0, 1, 5'd1, 32'hAAAA0001, 0, 0, 9'h0, 0, 0, 1, 0);
        tick();
        drive(0, 1, 5'd2, 32'hAAAA0002, 0, 0, 9'h0, 0, 0, 1, 0);
        tick(); idle();
        n = 0;
        while (lvl_a != 3'd0 && n < 20) begin tick(); n++; end
        chk("end_level", lvl_a, 3'd0);
        chk("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
